// File: rtl/seg_scan.sv
// seg_scan: keeps the four most recent result bytes and multiplexes them
// onto a 4-digit common seven-segment display (active-high digit select,
// active-low segments). HALT entries (0x80) blink at a frame-based rate.
module seg_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       freeze,
    output logic       in_ready,
    output logic [3:0] X,
    output logic [6:0] Y
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int FRM_W = $clog2(BLINK_FRAMES) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [6:0]       SEG_OFF  = 7'b1111111;

    logic [3:0][7:0]   r_h;
    logic [2:0]        r_fill;
    logic [1:0]        r_idx;
    logic [DIV_W-1:0]  r_div;
    logic [FRM_W-1:0]  r_frame;
    logic              r_blink;

    logic              w_accept;
    logic              w_div_tc;
    logic              w_frame_end;
    logic [7:0]        w_v;
    logic              w_blank;
    logic [6:0]        w_seg;

    // Glyph table for the processor's result encoding; unknown codes are blank.
    function automatic logic [6:0] seg_decode(input logic [7:0] v);
        logic [6:0] s;
        case (v)
            8'h00: s = 7'b0000001;
            8'h01: s = 7'b1001111;
            8'h02: s = 7'b0010010;
            8'h03: s = 7'b0000110;
            8'h04: s = 7'b1001100;
            8'h05: s = 7'b0100100;
            8'h06: s = 7'b0100000;
            8'h07: s = 7'b0001111;
            8'h08: s = 7'b0000000;
            8'h09: s = 7'b0000100;
            8'h0A: s = 7'b0001000;
            8'h0B: s = 7'b1100000;
            8'h0C: s = 7'b0110001;
            8'h0D: s = 7'b1000010;
            8'h0E: s = 7'b0110000;
            8'h0F: s = 7'b0111000;
            8'hFE: s = 7'b0100001;
            8'hFD: s = 7'b1110001;
            8'hFC: s = 7'b0110000;
            8'hFF: s = 7'b1000011;
            8'h80: s = 7'b1001000;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    assign in_ready    = ~freeze;
    assign w_accept    = in_valid & in_ready;
    assign w_div_tc    = (r_div == DIV_LAST);
    assign w_frame_end = w_div_tc && (r_idx == 2'd3);

    // Current digit's segments; unfilled slots and HALT blink-off phase go dark.
    always_comb begin
        w_v     = r_h[r_idx];
        w_blank = ({1'b0, r_idx} >= r_fill) || ((w_v == 8'h80) && r_blink);
        w_seg   = w_blank ? SEG_OFF : seg_decode(w_v);
    end

    // History shift register and saturating fill count; oldest entry falls off.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h    <= '0;
            r_fill <= 3'd0;
        end else if (w_accept) begin
            r_h <= {r_h[2:0], in_data};
            if (r_fill != 3'd4) begin
                r_fill <= r_fill + 3'd1;
            end
        end
    end

    // Digit divider and digit index; keeps running while frozen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
            r_idx <= 2'd0;
        end else if (w_div_tc) begin
            r_div <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Frame counter toggles the blink phase every BLINK_FRAMES full frames.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame <= '0;
            r_blink <= 1'b0;
        end else if (w_frame_end) begin
            if (r_frame == FRM_LAST) begin
                r_frame <= '0;
                r_blink <= ~r_blink;
            end else begin
                r_frame <= r_frame + FRM_W'(1);
            end
        end
    end

    // Registered pin outputs, both one cycle behind the internal scan state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            X <= 4'b0001;
            Y <= SEG_OFF;
        end else begin
            X <= 4'b0001 << r_idx;
            Y <= w_seg;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: a reference model derives the expected scan position
// and blink phase from the number of edges since reset release, and keeps
// the history as a plain array of the last four accepted bytes.
module tb_seg_scan;

    localparam int SD    = 4;
    localparam int BF    = 2;
    localparam int FRAME = 4 * SD;
    localparam int HALF  = FRAME * BF;

    logic       clk;
    logic       clk_en;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       freeze;
    logic       in_ready;
    logic [3:0] X;
    logic [6:0] Y;

    int total = 0;
    int bad   = 0;

    // reference model state
    int         k;
    logic [7:0] mh [4];
    int         mfill;
    logic [3:0] exp_x;
    logic [6:0] exp_y;

    logic [6:0] hex_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    seg_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .freeze   (freeze),
        .in_ready (in_ready),
        .X        (X),
        .Y        (Y)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    function automatic logic [6:0] ref_glyph(input logic [7:0] v);
        if (v < 8'h10) return hex_tab[v[3:0]];
        if (v == 8'hFE) return 7'b0100001;
        if (v == 8'hFD) return 7'b1110001;
        if (v == 8'hFC) return 7'b0110000;
        if (v == 8'hFF) return 7'b1000011;
        if (v == 8'h80) return 7'b1001000;
        return 7'b1111111;
    endfunction

    task automatic model_reset();
        k = 0;
        mfill = 0;
        for (int i = 0; i < 4; i++) mh[i] = 8'h00;
    endtask

    // Advance one clock edge; expected pins come from the pre-edge model state.
    task automatic tick();
        int idx;
        int bl;
        @(posedge clk);
        idx   = (k / SD) % 4;
        bl    = (k / HALF) % 2;
        exp_x = 4'b0001 << idx;
        if (idx >= mfill || (mh[idx] == 8'h80 && bl == 1)) exp_y = 7'b1111111;
        else exp_y = ref_glyph(mh[idx]);
        if (in_valid && !freeze) begin
            for (int i = 3; i > 0; i--) mh[i] = mh[i-1];
            mh[0] = in_data;
            if (mfill < 4) mfill++;
        end
        k++;
        #1;
    endtask

    task automatic align_frame();
        while (k % FRAME != 0) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; freeze = 1'b0; clk_en = 1'b0;
        #2 rst = 1'b0;
        #2;
        total++;
        if (X !== 4'b0001 || Y !== 7'b1111111 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_noclk: X=%b Y=%b rdy=%b want X=0001 Y=1111111 rdy=1", X, Y, in_ready);
        end
        model_reset();
        #2 rst = 1'b1;
        clk_en = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            total++;
            if (X !== exp_x || Y !== 7'b1111111) begin
                bad++;
                $display("FAIL reset_scan cyc=%0d: X=%b Y=%b want X=%b Y=1111111", i, X, Y, exp_x);
            end
        end
    endtask

    task automatic test_single_push();
        align_frame();
        in_valid = 1'b1; in_data = 8'h03;
        tick();
        in_valid = 1'b0;
        tick();
        total++;
        if (Y !== 7'b0000110 || X !== 4'b0001) begin
            bad++;
            $display("FAIL single_push: X=%b Y=%b want X=0001 Y=0000110", X, Y);
        end
        for (int i = 0; i < FRAME; i++) begin
            tick();
            total++;
            if (X !== exp_x || Y !== exp_y || (X != 4'b0001 && Y !== 7'b1111111)) begin
                bad++;
                $display("FAIL single_frame cyc=%0d: X=%b Y=%b want X=%b Y=%b", i, X, Y, exp_x, exp_y);
            end
        end
    endtask

    task automatic test_shift_drop();
        logic [6:0] seen [4];
        logic [7:0] vals [5] = '{8'h01, 8'h02, 8'h0A, 8'hFE, 8'hFD};
        logic [6:0] want [4] = '{7'b1110001, 7'b0100001, 7'b0001000, 7'b0010010};
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = vals[i];
            tick();
        end
        in_valid = 1'b0;
        tick();
        align_frame();
        for (int i = 0; i < FRAME; i++) begin
            tick();
            for (int d = 0; d < 4; d++) if (X == (4'b0001 << d)) seen[d] = Y;
            total++;
            if (X !== exp_x || Y !== exp_y) begin
                bad++;
                $display("FAIL shift_frame cyc=%0d: X=%b Y=%b want X=%b Y=%b", i, X, Y, exp_x, exp_y);
            end
        end
        for (int d = 0; d < 4; d++) begin
            total++;
            if (seen[d] !== want[d]) begin
                bad++;
                $display("FAIL shift_digit%0d: Y=%b want %b", d, seen[d], want[d]);
            end
        end
    endtask

    task automatic test_freeze_unknown();
        freeze = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL freeze_ready: in_ready=%b want 0", in_ready);
        end
        for (int i = 0; i < FRAME + 4; i++) begin
            in_valid = (i % 2 == 0); in_data = 8'h07;
            tick();
            total++;
            if (X !== exp_x || Y !== exp_y || (X == 4'b0001 && Y !== 7'b1110001)) begin
                bad++;
                $display("FAIL freeze_frame cyc=%0d: X=%b Y=%b want X=%b Y=%b", i, X, Y, exp_x, exp_y);
            end
        end
        in_valid = 1'b0; freeze = 1'b0;
        align_frame();
        in_valid = 1'b1; in_data = 8'h55;
        tick();
        in_valid = 1'b0;
        tick();
        total++;
        if (X !== 4'b0001 || Y !== 7'b1111111) begin
            bad++;
            $display("FAIL unknown_code: X=%b Y=%b want X=0001 Y=1111111", X, Y);
        end
    endtask

    task automatic test_halt_blink();
        int on_cnt = 0;
        int off_cnt = 0;
        align_frame();
        in_valid = 1'b1; in_data = 8'h80;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3 * HALF; i++) begin
            tick();
            if (X == 4'b0001 && Y == 7'b1001000) on_cnt++;
            if (X == 4'b0001 && Y == 7'b1111111) off_cnt++;
            total++;
            if (X !== exp_x || Y !== exp_y) begin
                bad++;
                $display("FAIL blink cyc=%0d k=%0d: X=%b Y=%b want X=%b Y=%b", i, k, X, Y, exp_x, exp_y);
            end
        end
        total++;
        if (on_cnt == 0 || off_cnt == 0) begin
            bad++;
            $display("FAIL blink_phases: on=%0d off=%0d want both nonzero", on_cnt, off_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 1) == 1);
            freeze   = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: in_data = 8'($urandom_range(0, 15));
                1: begin
                    case ($urandom_range(0, 4))
                        0: in_data = 8'h80;
                        1: in_data = 8'hFC;
                        2: in_data = 8'hFD;
                        3: in_data = 8'hFE;
                        default: in_data = 8'hFF;
                    endcase
                end
                default: in_data = 8'($urandom_range(0, 255));
            endcase
            tick();
            total++;
            if (X !== exp_x || Y !== exp_y || in_ready !== ~freeze) begin
                bad++;
                $display("FAIL random cyc=%0d: X=%b Y=%b rdy=%b want X=%b Y=%b rdy=%b",
                         i, X, Y, in_ready, exp_x, exp_y, ~freeze);
            end
        end
        in_valid = 1'b0; freeze = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'(i + 4);
            tick();
        end
        in_valid = 1'b0;
        while (k % FRAME != 6) tick();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        total++;
        if (X !== 4'b0001 || Y !== 7'b1111111) begin
            bad++;
            $display("FAIL reset_mid: X=%b Y=%b want X=0001 Y=1111111", X, Y);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            total++;
            if (X !== exp_x || Y !== 7'b1111111) begin
                bad++;
                $display("FAIL after_reset cyc=%0d: X=%b Y=%b want X=%b Y=1111111", i, X, Y, exp_x);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_shift_drop();
        test_freeze_unknown();
        test_halt_blink();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
